// File: rtl/fsm_2scomp_decode_if.sv
// Handshake/bus bundle for the serial two's-complement to sign-magnitude decoder.
// Latency: none, wires only.
// Backpressure: none; start is only honoured while the decoder is idle.
//
// Signals:
//   start - request pulse or level, sampled by the decoder only while idle
//   in    - two's-complement operand, captured on the accepting edge
//   mag   - unsigned magnitude of the last decoded word
//   sign  - sign of the last decoded word (1 = negative)
//   done  - one-cycle completion pulse
//   busy  - decoder is not idle
interface fsm_2scomp_decode_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic             done;
    logic             busy;

    // Producer side: drives the request and operand, observes the result.
    modport master (
        output start,
        output in,
        input  mag,
        input  sign,
        input  done,
        input  busy
    );

    // Decoder side.
    modport slave (
        input  start,
        input  in,
        output mag,
        output sign,
        output done,
        output busy
    );
endinterface

// File: rtl/fsm_2scomp_decode.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB-first over WIDTH cycles.
// Latency: start accepted at E0, done/mag/sign valid after E_WIDTH, idle again after E_WIDTH+1.
// Backpressure: none queued; start while busy (including the DONE cycle) is dropped.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset, forces idle and clears all state
//   bus   - slave modport of fsm_2scomp_decode_if (start/in in, mag/sign/done/busy out)
module fsm_2scomp_decode #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fsm_2scomp_decode_if.slave   bus
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Operand shift register, result accumulator and published result.
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mag_q;
    logic             neg_q;
    logic             seen_q;
    logic             sign_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;

    // Per-cycle decode terms.
    logic             cur_bit;
    logic             res_bit;
    logic             last_bit;
    logic [WIDTH-1:0] acc_nxt;

    // FSM control strobes.
    logic             accept;
    logic             step;
    logic             finish;

    // Negation of a negative word: bits up to and including the first 1
    // are copied, every bit above it is inverted. For non-negative words
    // neg_q is 0 so the XOR term vanishes and bits pass straight through.
    assign cur_bit  = sh_q[0];
    assign res_bit  = cur_bit ^ (neg_q & seen_q);
    assign last_bit = (cnt_q == LAST_IDX);

    // Result enters at the MSB and drifts right, so after WIDTH steps the
    // first-processed (LSB) bit sits at position 0.
    assign acc_nxt  = {res_bit, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last_bit) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Start is deliberately not looked at here: a request seen
                // in this cycle is dropped, not carried into IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q   <= '0;
            acc_q  <= '0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
            seen_q <= 1'b0;
            sign_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= finish;
            if (accept) begin
                sh_q   <= bus.in;
                neg_q  <= bus.in[WIDTH-1];
                acc_q  <= '0;
                seen_q <= 1'b0;
                cnt_q  <= '0;
            end else if (step) begin
                sh_q   <= {1'b0, sh_q[WIDTH-1:1]};
                acc_q  <= acc_nxt;
                seen_q <= seen_q | (neg_q & cur_bit);
                cnt_q  <= cnt_q + CW'(1);
                // Publish only the complete word, on the same edge that
                // absorbs the final bit, so mag/sign never show partials.
                if (finish) begin
                    mag_q  <= acc_nxt;
                    sign_q <= neg_q;
                end
            end
        end
    end

    assign bus.mag  = mag_q;
    assign bus.sign = sign_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_fsm_2scomp_decode.sv
// Self-checking bench for fsm_2scomp_decode: randomized and directed stimulus,
// scoreboard queue filled on acceptance and drained by a monitor on done.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge.
module tb_fsm_2scomp_decode;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;

    fsm_2scomp_decode_if #(.WIDTH(W)) bus();

    fsm_2scomp_decode #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         s;
        logic [W-1:0] m;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;

    res_t exp_q[$];
    int   m_rem;      // edges until the reference returns to idle
    res_t m_pend;     // result of the word in flight
    res_t m_out;      // result the outputs should currently show

    function automatic res_t ref_decode(input logic [W-1:0] v);
        res_t r;
        r.s = v[W-1];
        r.m = r.s ? (~v + 1'b1) : v;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: idle/busy timing as a countdown, result from plain arithmetic.
    initial begin
        m_rem  = 0;
        m_pend = '0;
        m_out  = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (reset !== 1'b1) begin
                m_rem = 0;
                m_out = '0;
                exp_q.delete();
            end else if (m_rem == 0) begin
                if (bus.start === 1'b1) begin
                    m_pend = ref_decode(bus.in);
                    exp_q.push_back(m_pend);
                    m_rem = W + 1;
                end
            end else begin
                m_rem--;
                if (m_rem == 1) m_out = m_pend;
            end
        end
    end

    // Monitor: cycle-accurate output check plus scoreboard pop on done.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                check("busy", int'(bus.busy), int'(m_rem != 0));
                check("done", int'(bus.done), int'(m_rem == 1));
                check("sign", int'(bus.sign), int'(m_out.s));
                check("mag",  int'(bus.mag),  int'(m_out.m));
                if (bus.done === 1'b1) begin
                    n_done++;
                    check("sb_nonempty", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_sign", int'(bus.sign), int'(e.s));
                        check("sb_mag",  int'(bus.mag),  int'(e.m));
                    end
                end
            end else begin
                check("rst_busy", int'(bus.busy), 0);
                check("rst_done", int'(bus.done), 0);
                check("rst_sign", int'(bus.sign), 0);
                check("rst_mag",  int'(bus.mag),  0);
            end
        end
    end

    task automatic pulse(input logic [W-1:0] v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = v;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_result(input string name, input logic s, input logic [W-1:0] m);
        check({name, "_sign"}, int'(bus.sign), int'(s));
        check({name, "_mag"},  int'(bus.mag),  int'(m));
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] neg_x;
        int           d0;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        #1 reset  = 1'b0;
        #1;
        check("por_mag",  int'(bus.mag),  0);
        check("por_busy", int'(bus.busy), 0);
        idle(3);
        #2 reset = 1'b1;

        // Basic negative word, single-cycle start.
        pulse(8'hFB);
        idle(12);
        expect_result("fb", 1'b1, 8'h05);

        // Boundary values.
        pulse(8'h00); idle(11); expect_result("b00", 1'b0, 8'h00);
        pulse(8'h7F); idle(11); expect_result("b7f", 1'b0, 8'h7F);
        pulse(8'hFF); idle(11); expect_result("bff", 1'b1, 8'h01);
        pulse(8'h80); idle(11); expect_result("b80", 1'b1, 8'h80);

        // Busy protection: extra starts mid-word and in the DONE cycle are
        // dropped, and operand changes after acceptance have no effect.
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 8'h05;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.start = (k == 3 || k == 9);
            bus.in    = bus.start ? 8'hFF : W'($urandom);
        end
        bus.start = 1'b0;
        idle(4);
        check("busy_one_done", n_done - d0, 1);
        expect_result("busy", 1'b0, 8'h05);

        // Reset in the middle of a word: immediate clear, no done.
        d0 = n_done;
        pulse(8'hFB);
        idle(2);
        #2 reset = 1'b0;
        #1;
        check("abort_mag",  int'(bus.mag),  0);
        check("abort_sign", int'(bus.sign), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_busy", int'(bus.busy), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        idle(12);
        check("abort_no_done", n_done - d0, 0);
        pulse(8'h81); idle(11); expect_result("r81", 1'b1, 8'h7F);

        // Round trip from the negation of known magnitudes.
        for (int i = 0; i < 3; i++) begin
            x     = (i == 0) ? 8'h05 : (i == 1) ? 8'h01 : 8'h80;
            neg_x = ~x + 1'b1;
            pulse(neg_x);
            idle(11);
            expect_result("rt", 1'b1, x);
        end

        // Exhaustive sweep, checked through the scoreboard.
        for (int i = 0; i < 256; i++) begin
            pulse(W'(i));
            idle(9);
        end

        // Start held high: accepted again at the first idle edge each time.
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bus.in = W'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        idle(12);
        check("held_done_count", n_done - d0, 6);

        // Random start/operand traffic.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.in    = W'($urandom);
        end
        bus.start = 1'b0;
        idle(15);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_2scomp_decode.md
# fsm_2scomp_decode

Bit-serial decoder that converts a two's-complement word back into sign-magnitude form. It is the inverse companion of the serial two's-complement negation FSM. It consumes a word on a `start` pulse, walks it LSB-first over WIDTH cycles, and presents `sign` plus unsigned `mag` with a one-cycle `done` pulse. It sits downstream of any block that produces two's-complement data and feeds logic that needs magnitude and sign separately.

## Interface
- WIDTH, 8, word width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; 0 forces idle
- start  input  1  request; sampled only in IDLE
- in  input  WIDTH  two's-complement operand; sampled on the accepting edge only
- mag  output  WIDTH  unsigned magnitude of last decoded word; registered
- sign  output  1  sign of last decoded word (1 = negative); registered
- done  output  1  one-cycle completion pulse; registered
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If `start`=1 at a clock edge: load `in` into the internal shift register, capture `neg = in[WIDTH-1]`, clear the bit counter and the `seen_one` flag, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: once per edge, take the shift-register LSB `b` and form the result bit `r`:
  - If `neg`=0: `r = b`.
  - If `neg`=1: `r = seen_one ? ~b : b`, then set `seen_one |= b`. This is the copy-through-first-1-then-invert rule.
  - Shift `r` into the result accumulator from the MSB side so that after WIDTH bits it is in natural order.
  - Increment the counter. When the WIDTH-th bit is processed, go to DONE.
- DONE:
  - On entry, `mag` is loaded with the accumulator and `sign` with `neg`.
  - `done`=1 for exactly this one state.
  - Next edge returns to IDLE unconditionally.
- Arithmetic rules:
  - `mag` is unsigned WIDTH bits, so the most negative input decodes without overflow. Example for WIDTH=8: 0x80 → sign=1, mag=0x80 (128).
  - Input 0 decodes to sign=0, mag=0; negative zero never occurs.
- `mag` and `sign` hold their value from one DONE until the next DONE. They never show partial results.
- `start` while `busy`=1, including in the DONE cycle, is ignored and not queued.
- Changes on `in` after the accepting edge have no effect on the operation in progress.

## Timing
- Reset values (asynchronous, immediate while `reset`=0): state=IDLE, mag=0, sign=0, done=0, busy=0, internal registers 0.
- Reset mid-operation aborts the operation immediately. `mag`/`sign` return to 0. No `done` is issued for the aborted word.
- Latency, with `start` accepted at edge E0:
  - busy=1 from E0.
  - The bits are processed on edges E1..E_WIDTH.
  - mag/sign update and done=1 at edge E_WIDTH.
  - done=0 and busy=0 at edge E_WIDTH+1.
  - For WIDTH=8: done is high in the 9th cycle after the accepting edge.
- Throughput: one word per WIDTH+2 cycles. The earliest next acceptance is edge E_WIDTH+2 (start must be held or re-asserted in IDLE).
- A single-cycle `start` pulse is sufficient. A `start` held high is accepted again at the first edge back in IDLE.

## Test plan
- in=0xFB, 1-cycle start → exactly 9 cycles later done=1 for one cycle, sign=1, mag=0x05; busy low one cycle after done.
- Boundary values: in=0x00 → sign=0, mag=0x00; in=0x7F → sign=0, mag=0x7F; in=0xFF → sign=1, mag=0x01; in=0x80 → sign=1, mag=0x80.
- Busy protection: start 0x05 accepted, then start with in=0xFF at cycles 3 and 9 (DONE) → only one done pulse, result sign=0, mag=0x05; `in` toggled mid-operation does not alter the result.
- Reset mid-operation: start 0xFB, pull reset low at cycle 4 for 1 cycle → mag=0, sign=0, done=0, busy=0 immediately with no done pulse; the next start 0x81 → sign=1, mag=0x7F.
- Round trip: feed the negation FSM output for 0x05, 0x01, 0x80 into this block → (1,0x05), (1,0x01), (1,0x80); sweep all 256 inputs against the reference model `sign=in[7]`, `mag = sign ? (~in+1) : in` (8-bit), with no mismatches.
- Back-to-back: start held high continuously → a done pulse every 10 cycles, each matching the current `in`.
